// File: rtl/weight_cache_pkg.sv
// weight_cache_pkg: shared widths, FSM states and matrix sizing for the weight cache
package weight_cache_pkg;
    localparam int LANES = 8;
    localparam int DATA_W = 64;
    localparam int DIM_W = 16;

    typedef enum logic [1:0] {IDLE, LOAD, CACHED} state_t;

    function automatic logic [31:0] total_words(input logic [DIM_W-1:0] rows, input logic [DIM_W-1:0] cols);
        return 32'(rows) * ((32'(cols) + 32'd7) >> 3);
    endfunction
endpackage

// File: rtl/weight_ram.sv
// weight_ram: simple dual-port synchronous RAM, one write port, one read port, 1-cycle read
module weight_ram
    import weight_cache_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // storage is never cleared, only overwritten by loads
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // read register holds its word between requests and clears on reset
    always_ff @(posedge clk or negedge reset)
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/weight_cache.sv
// weight_cache: loads one layer's weights from a stream and replays them to the systolic array
module weight_cache
    import weight_cache_pkg::*;
#(
    parameter int MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sData_valid,
    output logic              sData_ready,
    input  logic [DATA_W-1:0] sData_payload,
    input  logic [DIM_W-1:0]  Matrix_Row,
    input  logic [DIM_W-1:0]  Matrix_Col,
    input  logic              Raddr_Valid,
    input  logic              LayerEnd,
    output logic              Weight_Cached,
    output logic [DATA_W-1:0] mData,
    output logic [LANES-1:0]  MatrixCol_Switch
);
    localparam int AW = $clog2(MEM_DEPTH);

    state_t state_q, state_d;
    logic [AW-1:0] waddr, raddr, last;
    logic [DIM_W-1:0] row, row_n, col_n, rem;
    logic [DIM_W-4:0] grp;
    logic [LANES-1:0] lane_mask, sw_q;
    logic [31:0] tot;
    logic empty, wr_fire, rd_fire, row_end, addr_end;

    assign tot = total_words(Matrix_Row, Matrix_Col);
    assign sData_ready = state_q == LOAD && !empty;
    assign Weight_Cached = state_q == CACHED;
    assign wr_fire = sData_ready && sData_valid;
    assign rd_fire = Weight_Cached && Raddr_Valid && !empty;
    assign row_end = row == row_n - 1'b1;
    assign addr_end = raddr == last;
    assign rem = col_n - {grp, 3'b000};
    assign lane_mask = rem >= DIM_W'(LANES) ? '1 : (LANES'(1) << rem[2:0]) - LANES'(1);
    assign MatrixCol_Switch = sw_q;

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;

    // next state: start overrides everything, an empty matrix is cached at once
    always_comb begin
        state_d = state_q;
        if (start) state_d = LOAD;
        else if (LayerEnd && state_q != IDLE) state_d = IDLE;
        else if (state_q == LOAD && (empty || (wr_fire && waddr == last))) state_d = CACHED;
    end

    // matrix sizing, write/read addresses and the row/group counters that pick the lane mask
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            waddr <= '0;
            raddr <= '0;
            last <= '0;
            row <= '0;
            row_n <= '0;
            col_n <= '0;
            grp <= '0;
            empty <= 1'b0;
            sw_q <= '0;
        end else begin
            if (start) begin
                waddr <= '0;
                raddr <= '0;
                row <= '0;
                grp <= '0;
                row_n <= Matrix_Row;
                col_n <= Matrix_Col;
                last <= AW'(tot - 32'd1);
                empty <= tot == 32'd0;
            end else if (LayerEnd) begin
                raddr <= '0;
                row <= '0;
                grp <= '0;
            end else begin
                if (wr_fire) waddr <= waddr + 1'b1;
                if (rd_fire) begin
                    raddr <= addr_end ? '0 : raddr + 1'b1;
                    row <= (addr_end || row_end) ? '0 : row + 1'b1;
                    grp <= addr_end ? '0 : row_end ? grp + 1'b1 : grp;
                end
            end
            sw_q <= rd_fire ? lane_mask : '0;
        end

    weight_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_fire),
        .waddr (waddr),
        .wdata (sData_payload),
        .re    (rd_fire),
        .raddr (raddr),
        .rdata (mData)
    );
endmodule

// File: tb/tb_weight_cache.sv
// tb_weight_cache: directed bench with a read scoreboard for weight_cache
module tb_weight_cache;
    logic clk = 1'b0;
    logic reset, start, sData_valid, sData_ready, Raddr_Valid, LayerEnd, Weight_Cached;
    logic [63:0] sData_payload, mData;
    logic [15:0] Matrix_Row, Matrix_Col;
    logic [7:0] MatrixCol_Switch;

    int checks = 0;
    int failures = 0;
    int total, rows, cols, ridx, beats;
    logic [63:0] ref_mem [4096];
    logic [63:0] last_d = '0;
    logic [71:0] sb [$];

    weight_cache dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .sData_valid      (sData_valid),
        .sData_ready      (sData_ready),
        .sData_payload    (sData_payload),
        .Matrix_Row       (Matrix_Row),
        .Matrix_Col       (Matrix_Col),
        .Raddr_Valid      (Raddr_Valid),
        .LayerEnd         (LayerEnd),
        .Weight_Cached    (Weight_Cached),
        .mData            (mData),
        .MatrixCol_Switch (MatrixCol_Switch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_sw(input int idx);
        int rem;
        rem = cols - 8 * (idx / rows);
        return rem >= 8 ? 8'hFF : 8'((1 << rem) - 1);
    endfunction

    task automatic do_load(input int r, input int c, input bit gaps, input int upto);
        int cyc;
        Matrix_Row = 16'(r);
        Matrix_Col = 16'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        LayerEnd = 1'b0;
        rows = r;
        cols = c;
        total = r * ((c + 7) / 8);
        ridx = 0;
        beats = 0;
        cyc = 0;
        while (beats < upto && cyc < 20000) begin
            sData_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            sData_payload = {$urandom, $urandom};
            if (sData_valid && sData_ready) begin
                ref_mem[beats] = sData_payload;
                beats++;
            end
            tick();
            cyc++;
        end
        sData_valid = 1'b0;
        chk("load_beats", 64'(beats), 64'(upto));
    endtask

    task automatic do_read(input int n, input bit gaps);
        logic [71:0] e;
        for (int i = 0; i < n; i++) begin
            Raddr_Valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (Raddr_Valid) begin
                sb.push_back({exp_sw(ridx), ref_mem[ridx]});
                ridx = (ridx + 1) % total;
            end
            tick();
            if (Raddr_Valid) begin
                e = sb.pop_front();
                chk("rd_data", mData, e[63:0]);
                chk("rd_sw", 64'(MatrixCol_Switch), 64'(e[71:64]));
                last_d = e[63:0];
            end else begin
                chk("idle_sw", 64'(MatrixCol_Switch), 64'd0);
                chk("idle_hold", mData, last_d);
            end
        end
        Raddr_Valid = 1'b0;
    endtask

    task automatic chk_loaded();
        chk("ready_fall", 64'(sData_ready), 64'd0);
        chk("cached_rise", 64'(Weight_Cached), 64'd1);
        sData_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ready_stays_low", 64'(sData_ready), 64'd0);
        end
        sData_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sData_valid = 1'b0;
        sData_payload = '0;
        Matrix_Row = '0;
        Matrix_Col = '0;
        Raddr_Valid = 1'b0;
        LayerEnd = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(sData_ready), 64'd0);
        chk("rst_cached", 64'(Weight_Cached), 64'd0);
        chk("rst_mdata", mData, 64'd0);
        chk("rst_sw", 64'(MatrixCol_Switch), 64'd0);
        reset = 1'b1;
        tick();
        Raddr_Valid = 1'b1;
        tick();
        chk("idle_read_ignored", 64'(MatrixCol_Switch), 64'd0);
        Raddr_Valid = 1'b0;

        do_load(432, 35, 1'b0, 2160);
        chk_loaded();
        do_read(2161, 1'b0);
        do_read(300, 1'b1);

        do_load(432, 35, 1'b1, 2160);
        chk_loaded();
        do_read(200, 1'b1);

        do_read(50, 1'b0);
        LayerEnd = 1'b1;
        tick();
        LayerEnd = 1'b0;
        chk("layerend_cached", 64'(Weight_Cached), 64'd0);
        chk("layerend_ready", 64'(sData_ready), 64'd0);
        Raddr_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_end_sw", 64'(MatrixCol_Switch), 64'd0);
            chk("after_end_hold", mData, last_d);
        end
        Raddr_Valid = 1'b0;
        do_load(432, 35, 1'b1, 2160);
        chk_loaded();
        do_read(40, 1'b1);

        do_load(432, 35, 1'b0, 1000);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 64'(sData_ready), 64'd0);
        chk("midrst_cached", 64'(Weight_Cached), 64'd0);
        chk("midrst_mdata", mData, 64'd0);
        chk("midrst_sw", 64'(MatrixCol_Switch), 64'd0);
        last_d = '0;
        tick();
        reset = 1'b1;
        tick();
        do_load(432, 35, 1'b0, 2160);
        chk_loaded();
        do_read(20, 1'b0);

        LayerEnd = 1'b1;
        do_load(9, 16, 1'b0, 18);
        chk_loaded();
        do_read(19, 1'b0);
        do_read(40, 1'b1);

        Matrix_Row = 16'd0;
        Matrix_Col = 16'd35;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("empty_cached", 64'(Weight_Cached), 64'd1);
        chk("empty_ready", 64'(sData_ready), 64'd0);
        Raddr_Valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("empty_sw", 64'(MatrixCol_Switch), 64'd0);
        end
        Raddr_Valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_cache.md
Name: weight_cache

Overview:
- Stores one layer's weight matrix in on-chip RAM, loaded from a 64-bit valid/ready stream.
- Replays the stored words to the 8x8 systolic array, one word per read request, where each word holds 8 output-channel lanes × 8 bits.
- The activation (img2col) streamer issues the read requests.
- Signals when the weights are cached, so the activation streamer can start, and releases the cache at layer end.

Parameters:
DATA_W, 64, width of stream word and of mData (8 lanes × 8 bit)
LANES, 8, systolic array columns per word
MEM_DEPTH, 4096, weight RAM depth in words (must be ≥ Matrix_Row × ceil(Matrix_Col/8))
DIM_W, 16, width of the Matrix_Row and Matrix_Col inputs

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a weight load
sData_valid  in  1  load stream valid
sData_ready  out  1  load stream ready
sData_payload  in  64  load word (byte i = output-channel lane i)
Matrix_Row  in  16  rows per column group (K×K×Cin, e.g. 432)
Matrix_Col  in  16  output channels (e.g. 35)
Raddr_Valid  in  1  read request: output the next weight word
LayerEnd  in  1  one-cycle pulse that ends the layer
Weight_Cached  out  1  high while the full matrix is resident
mData  out  64  weight word to the array
MatrixCol_Switch  out  8  per-lane valid for mData

Behaviour:
- Derived values:
  - GROUPS = (Matrix_Col+7)>>3.
  - TOTAL = Matrix_Row × GROUPS.
  - Both are sampled on start and held until the next start.
- Reset (reset=0): state IDLE; sData_ready=0, Weight_Cached=0, mData=0, MatrixCol_Switch=0; all address and counter registers cleared. RAM contents are not cleared.
- IDLE:
  - sData_ready=0; Raddr_Valid is ignored.
  - start → LOAD, with write address=0.
- LOAD:
  - sData_ready=1.
  - Each cycle with valid&ready: write payload to RAM[waddr] and increment waddr.
  - The beat at waddr==TOTAL-1 → CACHED. sData_ready is 0 from the following cycle, so exactly TOTAL beats are accepted.
  - A second start in LOAD restarts the load at waddr=0.
- CACHED:
  - Weight_Cached=1 (registered; goes high the cycle after the last beat).
  - Each Raddr_Valid cycle reads RAM[raddr]. mData and MatrixCol_Switch are updated one cycle later (fixed latency 1).
  - Address counters: row counter 0..Matrix_Row-1 and group counter 0..GROUPS-1. raddr increments each read.
  - After raddr==TOTAL-1, raddr, row and group all wrap to 0, so the matrix replays for the next output window.
  - MatrixCol_Switch[i] = 1 when i < min(8, Matrix_Col - 8×group) for the group of the word read; otherwise 0.
  - Cycles without Raddr_Valid: MatrixCol_Switch=0 and mData holds its value.
- LayerEnd in CACHED (or LOAD) → IDLE. Weight_Cached and sData_ready go to 0 next cycle; raddr, row and group clear.
- start and LayerEnd in the same cycle: start wins → LOAD.
- Matrix_Row==0 or Matrix_Col==0: load completes immediately; Weight_Cached=1 and no reads return valid lanes.
- Loaded words are output bit-exact; no arithmetic is applied to the data.

Decomposition:
- Shared package: LANES, DATA_W, DIM_W, and the state enum {IDLE, LOAD, CACHED}.
- One sub-module, weight_ram: simple dual-port synchronous RAM, MEM_DEPTH × DATA_W, with one write port and one read port, 1-cycle read latency.
- Control FSM and counters live in weight_cache.

Test Plan:
- Load with Matrix_Row=432, Matrix_Col=35, continuous valid, start pulse → exactly 2160 beats accepted. sData_ready falls after beat 2160; Weight_Cached=1 one cycle later.
- Then 2160 back-to-back Raddr_Valid → mData equals the loaded words in order with 1-cycle latency. MatrixCol_Switch=0xFF for reads 0..1727 and 0x07 for reads 1728..2159; read 2160 returns word 0 (wrap).
- Random gaps on sData_valid and Raddr_Valid → no lost or duplicated words. MatrixCol_Switch=0 on idle cycles.
- LayerEnd mid-readout → Weight_Cached=0 next cycle; Raddr_Valid then ignored. A new start reloads, and readout restarts at word 0.
- reset asserted mid-load (beat 1000) → outputs 0 immediately. After release and start, a full reload of 2160 beats is required.
- Matrix_Col=16, Matrix_Row=9 → TOTAL=18; all reads give MatrixCol_Switch=0xFF; wrap after 18 reads.
